// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives the select input of a 4:1 mux and steps through
// the enabled channels in ascending order, holding each one for a programmable
// dwell time. At the end of each dwell it samples the mux output into the result
// word, then offers that word downstream on a valid/ready handshake.
//
// Optional build feature:
//   SCAN_CONTINUOUS_EN - on the DONE handshake edge, ch_en and dwell are
//   re-sampled and a new scan starts at once, with no IDLE cycle. If the
//   re-sampled mask is empty, the block returns to IDLE instead.
//   When the macro is undefined, every scan needs its own start pulse.
module mux_scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         ch_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  input  logic               mux_out,
  output logic [3:0]         result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [3:0]         result_q, result_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [3:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dw_q, dw_d;

  logic [2:0]         nxt_s;
  logic [DWELL_W-1:0] eff_dwell_s;

  // A dwell of 0 would mean "never sample", so it is promoted to 1.
  function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
    logic [DWELL_W-1:0] r;
    if (d == {DWELL_W{1'b0}}) begin
      r = DWELL_W'(1);
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Lowest enabled channel whose index is >= from.
  // Returns {found, index}; found=0 means no such channel.
  function automatic logic [2:0] pick(input logic [3:0] mask, input int from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if ((i >= from) && mask[i]) begin
        r = {1'b1, 2'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Next-state and next-output logic for the scan controller.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    result_d    = result_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    dw_d        = dw_q;
    nxt_s       = 3'b000;
    eff_dwell_s = eff_dwell(dwell);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d   = ch_en;
          dw_d     = eff_dwell_s;
          result_d = 4'b0000;
          nxt_s    = pick(ch_en, 0);
          if (nxt_s[2]) begin
            state_d = S_DWELL;
            sel_d   = nxt_s[1:0];
            cnt_d   = eff_dwell_s - DWELL_W'(1);
          end else begin
            // An empty mask still produces a (zero) result word.
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DWELL: begin
        if (cnt_q == {DWELL_W{1'b0}}) begin
          result_d[sel_q] = mux_out;
          nxt_s           = pick(mask_q, int'(sel_q) + 1);
          if (nxt_s[2]) begin
            sel_d = nxt_s[1:0];
            cnt_d = dw_q - DWELL_W'(1);
          end else begin
            state_d = S_DONE;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      S_DONE: begin
        if (!valid_q) begin
          // Entered directly from IDLE with an empty mask: raise valid one cycle later.
          valid_d = 1'b1;
        end else if (result_ready) begin
          valid_d = 1'b0;
`ifdef SCAN_CONTINUOUS_EN
          mask_d = ch_en;
          dw_d   = eff_dwell_s;
          nxt_s  = pick(ch_en, 0);
          if (nxt_s[2]) begin
            state_d  = S_DWELL;
            sel_d    = nxt_s[1:0];
            cnt_d    = eff_dwell_s - DWELL_W'(1);
            result_d = 4'b0000;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears everything, including a pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= 2'b00;
      result_q <= 4'b0000;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= {DWELL_W{1'b0}};
      mask_q   <= 4'b0000;
      dw_q     <= {DWELL_W{1'b0}};
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      dw_q     <= dw_d;
    end
  end

  assign sel          = sel_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: directed scans plus randomized scans checked
// against a reference built from the scan rules (enabled-channel list, D' per
// channel, result = data & mask).
module tb_mux_scan_sequencer;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    ch_en;
  logic [DW-1:0] dwell;
  logic [1:0]    sel;
  logic          mux_out;
  logic [3:0]    result;
  logic          result_valid;
  logic          result_ready;
  logic          busy;
  logic [3:0]    data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural 4:1 mux.
  assign mux_out = data[sel];

  mux_scan_sequencer #(.DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_en(ch_en), .dwell(dwell),
    .sel(sel), .mux_out(mux_out), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete scan: start, per-cycle select/valid checks, backpressure, accept.
  task automatic run_scan(input logic [3:0] m, input logic [3:0] dw, input logic [3:0] d,
                          input int hold, input bit early);
    int dp, n, len;
    int chs[$];
    logic [3:0] exp;
    dp = (dw == 4'd0) ? 1 : int'(dw);
    for (int i = 0; i < 4; i++) if (m[i]) chs.push_back(i);
    n   = chs.size();
    len = n * dp;
    exp = d & m;

    data = d; ch_en = m; dwell = dw; start = 1'b1; result_ready = 1'b0;
    step();                                // edge k
    start = 1'b0;
    ch_en = 4'($urandom_range(0, 15));     // must not affect the running scan
    dwell = 4'($urandom_range(0, 15));
    if (early) result_ready = 1'b1;

    if (n == 0) begin
      chk("empty_busy", 32'(busy), 32'd1);
      chk("empty_valid_low", 32'(result_valid), 32'd0);
      step();
    end else begin
      for (int t = 0; t < len; t++) begin
        chk("scan_sel", 32'(sel), 32'(chs[t / dp]));
        chk("scan_valid_low", 32'(result_valid), 32'd0);
        chk("scan_busy", 32'(busy), 32'd1);
        step();
      end
      chk("done_sel_hold", 32'(sel), 32'(chs[n - 1]));
    end
    chk("done_valid", 32'(result_valid), 32'd1);
    chk("done_result", 32'(result), 32'(exp));
    chk("done_busy", 32'(busy), 32'd1);

    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        start = 1'b1;
        ch_en = 4'($urandom_range(0, 15));
        step();
        chk("bp_valid", 32'(result_valid), 32'd1);
        chk("bp_result", 32'(result), 32'(exp));
        chk("bp_busy", 32'(busy), 32'd1);
      end
      start = 1'b0;
      result_ready = 1'b1;
    end
    step();                                // accept edge
    result_ready = 1'b0;
    chk("acc_valid", 32'(result_valid), 32'd0);
    chk("acc_busy", 32'(busy), 32'd0);
    chk("acc_result_kept", 32'(result), 32'(exp));
    step();
    chk("idle_no_restart", 32'(busy), 32'd0);
    chk("idle_valid", 32'(result_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ch_en = 4'd0; dwell = 4'd0;
    result_ready = 1'b0; data = 4'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-DWELL with nonzero sel and a partial result.
    data = 4'b1111; ch_en = 4'b1010; dwell = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("pre_rst_sel", 32'(sel), 32'd3);
    chk("pre_rst_result", 32'(result), 32'b0010);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_valid", 32'(result_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Directed scans.
    run_scan(4'b1111, 4'd2, 4'b1010, 3, 1'b0);   // full scan
    run_scan(4'b0101, 4'd0, 4'b1111, 2, 1'b0);   // sparse, dwell 0 -> 1
    run_scan(4'b0000, 4'd7, 4'b1111, 0, 1'b1);   // empty mask, ready early
    run_scan(4'b0110, 4'd3, 4'b0100, 5, 1'b0);   // backpressure
    run_scan(4'b1000, 4'd15, 4'b1000, 1, 1'b1);  // max dwell, ready on entry

    // Randomized scans.
    for (int r = 0; r < 20; r++) begin
      run_scan(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
               1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
